pim_tile_scheduler: RTL

PIM_TILE_SCHEDULER -- requirements
Module: pim_tile_scheduler

---
 rtl/pim_tile_scheduler_if.sv | 29 ++
 rtl/pim_tile_scheduler.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pim_tile_scheduler_if.sv
// Bundles the job-request, PIM launch/result and aggregator signals of the tile scheduler.
// Handshake: start is a one-cycle request taken only while busy is low (no ready, no queuing);
// pim_start, agg_valid, done and error are one-cycle pulses; pim_valid may be a pulse or a level.
interface pim_tile_scheduler_if #(
    parameter int MAX_PIM_UNITS = 4
);
    logic                     start;
    logic [15:0]              matrix_size;
    logic [3:0]               pim_units_used;
    logic [MAX_PIM_UNITS-1:0] pim_start;
    logic [15:0]              tile_row_off;
    logic [15:0]              tile_col_off;
    logic [MAX_PIM_UNITS-1:0] pim_valid;
    logic [MAX_PIM_UNITS-1:0] agg_valid;
    logic                     busy;
    logic                     done;
    logic                     error;
    logic [2:0]               dbg_state;

    modport slave (
        input  start, matrix_size, pim_units_used, pim_valid,
        output pim_start, tile_row_off, tile_col_off, agg_valid, busy, done, error, dbg_state
    );

    modport master (
        output start, matrix_size, pim_units_used, pim_valid,
        input  pim_start, tile_row_off, tile_col_off, agg_valid, busy, done, error, dbg_state
    );
endinterface

// File: rtl/pim_tile_scheduler.sv
// Splits a square operand into PIM_MATRIX_SIZE tiles, launches one tile per unit, then waits
// (with timeout) for every launched unit to report before handing the unit mask to the aggregator.
module pim_tile_scheduler #(
    parameter int MAX_PIM_UNITS   = 4,
    parameter int PIM_MATRIX_SIZE = 8,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    pim_tile_scheduler_if.slave   bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CHECK    = 3'd1;
    localparam logic [2:0] S_DISPATCH = 3'd2;
    localparam logic [2:0] S_WAIT     = 3'd3;
    localparam logic [2:0] S_COLLECT  = 3'd4;
    localparam logic [2:0] S_ERR      = 3'd5;

    localparam int                       CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [MAX_PIM_UNITS-1:0] UNIT0   = MAX_PIM_UNITS'(1);
    localparam logic [15:0]              TILE    = 16'(PIM_MATRIX_SIZE);
    localparam logic [CW-1:0]            CNT_END = CW'(TIMEOUT_CYCLES - 1);

    logic [2:0]               state_q, state_d;
    logic [15:0]              size_q, size_d;
    logic [3:0]               units_q, units_d;
    logic [15:0]              tps_q, tps_d;
    logic [15:0]              ntiles_q, ntiles_d;
    logic [15:0]              k_q, k_d;
    logic [15:0]              col_idx_q, col_idx_d;
    logic [15:0]              row_q, row_d;
    logic [15:0]              col_q, col_d;
    logic [MAX_PIM_UNITS-1:0] launched_q, launched_d;
    logic [MAX_PIM_UNITS-1:0] collected_q, collected_d;
    logic [CW-1:0]            wcnt_q, wcnt_d;

    logic [16:0]              sum_c;
    logic [15:0]              tps_c;
    logic [31:0]              ntiles_c;
    logic                     cfg_bad_c;
    logic [MAX_PIM_UNITS-1:0] launch_c;
    logic [MAX_PIM_UNITS-1:0] mask_now_c;

    // Tile count is checked at 32 bits so oversized operands cannot wrap into a passing count.
    always_comb begin
        sum_c     = {1'b0, size_q} + 17'(PIM_MATRIX_SIZE - 1);
        tps_c     = 16'(sum_c / 17'(PIM_MATRIX_SIZE));
        ntiles_c  = 32'(tps_c) * 32'(tps_c);
        cfg_bad_c = (size_q == 16'd0) || (units_q == 4'd0) ||
                    (32'(units_q) > 32'(MAX_PIM_UNITS)) || (ntiles_c > 32'(units_q));
        launch_c   = (state_q == S_DISPATCH) ? (UNIT0 << k_q) : '0;
        mask_now_c = collected_q | (bus.pim_valid & (launched_q | launch_c));
    end

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        units_d     = units_q;
        tps_d       = tps_q;
        ntiles_d    = ntiles_q;
        k_d         = k_q;
        col_idx_d   = col_idx_q;
        row_d       = row_q;
        col_d       = col_q;
        launched_d  = launched_q;
        collected_d = collected_q;
        wcnt_d      = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    size_d      = bus.matrix_size;
                    units_d     = bus.pim_units_used;
                    collected_d = '0;
                    launched_d  = '0;
                    k_d         = '0;
                    col_idx_d   = '0;
                    row_d       = '0;
                    col_d       = '0;
                    wcnt_d      = '0;
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: begin
                tps_d    = tps_c;
                ntiles_d = 16'(ntiles_c);
                state_d  = cfg_bad_c ? S_ERR : S_DISPATCH;
            end
            S_DISPATCH: begin
                launched_d  = launched_q | launch_c;
                collected_d = mask_now_c;
                if (k_q == ntiles_q - 16'd1) begin
                    wcnt_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    k_d = k_q + 16'd1;
                    // Walk tiles in row-major order without dividing by tiles_per_side.
                    if (col_idx_q == tps_q - 16'd1) begin
                        col_idx_d = '0;
                        col_d     = '0;
                        row_d     = row_q + TILE;
                    end else begin
                        col_idx_d = col_idx_q + 16'd1;
                        col_d     = col_q + TILE;
                    end
                end
            end
            S_WAIT: begin
                collected_d = mask_now_c;
                if (mask_now_c == launched_q) begin
                    state_d = S_COLLECT;
                end else if (wcnt_q == CNT_END) begin
                    state_d = S_ERR;
                end else begin
                    wcnt_d = wcnt_q + CW'(1);
                end
            end
            S_COLLECT: state_d = S_IDLE;
            S_ERR:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            size_q      <= '0;
            units_q     <= '0;
            tps_q       <= '0;
            ntiles_q    <= '0;
            k_q         <= '0;
            col_idx_q   <= '0;
            row_q       <= '0;
            col_q       <= '0;
            launched_q  <= '0;
            collected_q <= '0;
            wcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            units_q     <= units_d;
            tps_q       <= tps_d;
            ntiles_q    <= ntiles_d;
            k_q         <= k_d;
            col_idx_q   <= col_idx_d;
            row_q       <= row_d;
            col_q       <= col_d;
            launched_q  <= launched_d;
            collected_q <= collected_d;
            wcnt_q      <= wcnt_d;
        end
    end

    always_comb begin
        bus.pim_start    = launch_c;
        bus.tile_row_off = (state_q == S_DISPATCH) ? row_q : 16'd0;
        bus.tile_col_off = (state_q == S_DISPATCH) ? col_q : 16'd0;
        bus.agg_valid    = (state_q == S_COLLECT) ? launched_q : '0;
        bus.busy         = (state_q != S_IDLE);
        bus.done         = (state_q == S_COLLECT);
        bus.error        = (state_q == S_ERR);
        bus.dbg_state    = state_q;
    end
endmodule
